enemy_formation: RTL and testbench

- Parametrised controller for the invader formation: owns the formation origin, sweep direction, step timer, descent and speed-up policy, and the invasion flag.
- Driven by the per-enemy alive mask. Also answers the VGA pixel query "which enemy cell covers this pixel, and is it alive" through a fixed 2-cycle pipeline.
- Sits between the game FSM (run/restart) and the enemy sprite renderers. Replaces the hard-coded movement loop with per-column bounds and kill-based speed-up.

---
 rtl/enemy_formation.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_enemy_formation.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_formation.sv
// enemy_formation: invader formation controller.
// Owns the formation origin, sweep direction, step timer, descent and
// kill-based speed-up, and the sticky invasion flag. It also answers the
// renderer's per-pixel query "which cell covers this pixel, and is that
// enemy alive" through a fixed two-stage pipeline.
module enemy_formation #(
  parameter int ROWS         = 5,
  parameter int COLS         = 13,
  parameter int CELL_W       = 30,
  parameter int CELL_H       = 30,
  parameter int SPRITE_W     = 20,
  parameter int SPRITE_H     = 16,
  parameter int X_START      = 150,
  parameter int Y_START      = 40,
  parameter int X_MIN        = 120,
  parameter int X_MAX        = 760,
  parameter int Y_LIMIT      = 440,
  parameter int DY           = 50,
  parameter int STEP_PERIOD  = 2097152,
  parameter int BASE_DX      = 1,
  parameter int MAX_DX       = 8,
  parameter int KILLS_PER_DX = 8,
  localparam int N           = ROWS * COLS,
  localparam int IDX_W       = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic             run,
  input  logic [N-1:0]     alive,
  input  logic [9:0]       h_counter,
  input  logic [9:0]       v_counter,
  output logic [10:0]      origin_x,
  output logic [10:0]      origin_y,
  output logic             direction,
  output logic [3:0]       dx_cur,
  output logic             step_pulse,
  output logic             descend_pulse,
  output logic             invaded,
  output logic [IDX_W-1:0] pix_idx,
  output logic             pix_hit
);

  localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int TIMER_W = (STEP_PERIOD > 1) ? $clog2(STEP_PERIOD) : 1;

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(STEP_PERIOD - 1);

  localparam logic [10:0] CELL_W11   = 11'(CELL_W);
  localparam logic [10:0] CELL_H11   = 11'(CELL_H);
  localparam logic [10:0] SPRITE_W11 = 11'(SPRITE_W);
  localparam logic [10:0] SPRITE_H11 = 11'(SPRITE_H);
  localparam logic [10:0] X_START11  = 11'(X_START);
  localparam logic [10:0] Y_START11  = 11'(Y_START);
  localparam logic [10:0] X_MIN11    = 11'(X_MIN);
  localparam logic [10:0] X_MAX11    = 11'(X_MAX);
  localparam logic [10:0] Y_LIMIT11  = 11'(Y_LIMIT);
  localparam logic [10:0] DY11       = 11'(DY);

  localparam logic signed [11:0] FORM_W12 = 12'(COLS * CELL_W);
  localparam logic signed [11:0] FORM_H12 = 12'(ROWS * CELL_H);

  typedef enum logic {
    SWEEP   = 1'b0,
    DESCEND = 1'b1
  } state_t;

  logic               clear;

  state_t             state_q, state_d;
  logic [10:0]        originX_q, originX_d;
  logic [10:0]        originY_q, originY_d;
  logic               dir_q, dir_d;
  logic [3:0]         descents_q, descents_d;
  logic [3:0]         dx_q, dx_d;
  logic               stepPulse_q, stepPulse_d;
  logic               descendPulse_q, descendPulse_d;
  logic               invaded_q, invaded_d;
  logic [TIMER_W-1:0] timer_q;

  logic [COL_W-1:0]   lc_q, lc_d;
  logic [COL_W-1:0]   rc_q, rc_d;
  logic [ROW_W-1:0]   br_q, br_d;
  logic               none_q, none_d;
  logic [COLS-1:0]    colAny;
  logic [ROWS-1:0]    rowAny;

  logic               timerEn;
  logic               tick;
  logic [10:0]        rightEdge;
  logic [10:0]        leftEdge;
  logic [10:0]        leftLimit;
  logic [10:0]        bottomEdge;

  int unsigned        aliveCount;
  int unsigned        killCount;
  int unsigned        dxSum;

  logic signed [11:0] rxFull, ryFull;
  logic [10:0]        rx_q, ry_q;
  logic               inForm_q, inForm_d;
  logic [COL_W-1:0]   colSel;
  logic [ROW_W-1:0]   rowSel;
  logic [10:0]        colBase, rowBase;
  logic [10:0]        rxMod, ryMod;
  logic [IDX_W-1:0]   cellIdx;
  logic               aliveSel;
  logic [IDX_W-1:0]   pixIdx_q, pixIdx_d;
  logic               pixHit_q, pixHit_d;

  assign clear   = reset | restart;
  assign timerEn = run & ~invaded_q;
  assign tick    = timerEn & (timer_q == TIMER_LAST);

  // Step timer: free-runs while enabled and wraps on the motion tick.
  always_ff @(posedge clk) begin
    if (clear) begin
      timer_q <= '0;
    end else if (timerEn) begin
      timer_q <= tick ? '0 : timer_q + 1'b1;
    end
  end

  // Occupancy bounds of the current alive mask: leftmost/rightmost column and bottom row.
  always_comb begin
    colAny = '0;
    rowAny = '0;
    lc_d   = '0;
    rc_d   = '0;
    br_d   = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (alive[r*COLS + c]) begin
          colAny[c] = 1'b1;
          rowAny[r] = 1'b1;
        end
      end
    end
    for (int c = COLS - 1; c >= 0; c--) begin
      if (colAny[c]) lc_d = COL_W'(c);
    end
    for (int c = 0; c < COLS; c++) begin
      if (colAny[c]) rc_d = COL_W'(c);
    end
    for (int r = 0; r < ROWS; r++) begin
      if (rowAny[r]) br_d = ROW_W'(r);
    end
    none_d = (alive == '0);
  end

  // Bounds are registered so that a kill landing on a tick cycle only affects later ticks.
  always_ff @(posedge clk) begin
    if (clear) begin
      lc_q   <= '0;
      rc_q   <= '0;
      br_q   <= '0;
      none_q <= 1'b1;
    end else begin
      lc_q   <= lc_d;
      rc_q   <= rc_d;
      br_q   <= br_d;
      none_q <= none_d;
    end
  end

  // Speed policy: one extra pixel per descent and per batch of kills, capped.
  always_comb begin
    aliveCount = 0;
    for (int i = 0; i < N; i++) begin
      aliveCount = aliveCount + 32'(alive[i]);
    end
    killCount = 32'(N) - aliveCount;
    dxSum     = 32'(BASE_DX) + 32'(descents_q) + killCount / 32'(KILLS_PER_DX);
    dx_d      = (dxSum > 32'(MAX_DX)) ? 4'(MAX_DX) : dxSum[3:0];
  end

  assign rightEdge  = originX_q + 11'(rc_q) * CELL_W11 + SPRITE_W11 - 11'd1 + 11'(dx_q);
  assign leftEdge   = originX_q + 11'(lc_q) * CELL_W11;
  assign leftLimit  = X_MIN11 + 11'(dx_q);
  assign bottomEdge = originY_q + 11'(br_q) * CELL_H11 + SPRITE_H11;

  // Motion FSM: on each tick either step sideways, turn at a wall, or drop one row.
  always_comb begin
    state_d        = state_q;
    originX_d      = originX_q;
    originY_d      = originY_q;
    dir_d          = dir_q;
    descents_d     = descents_q;
    stepPulse_d    = 1'b0;
    descendPulse_d = 1'b0;
    if (tick && !none_q) begin
      stepPulse_d = 1'b1;
      case (state_q)
        SWEEP: begin
          if (!dir_q) begin
            if (rightEdge > X_MAX11) begin
              dir_d   = 1'b1;
              state_d = DESCEND;
            end else begin
              originX_d = originX_q + 11'(dx_q);
            end
          end else begin
            if (leftEdge < leftLimit) begin
              dir_d   = 1'b0;
              state_d = DESCEND;
            end else begin
              originX_d = originX_q - 11'(dx_q);
            end
          end
        end
        DESCEND: begin
          originY_d      = originY_q + DY11;
          descents_d     = (descents_q == 4'hF) ? 4'hF : descents_q + 4'd1;
          descendPulse_d = 1'b1;
          state_d        = SWEEP;
        end
        default: state_d = SWEEP;
      endcase
    end
  end

  assign invaded_d = invaded_q | (~none_q & (bottomEdge >= Y_LIMIT11));

  // Formation state register; restart has priority over any tick in flight.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q        <= SWEEP;
      originX_q      <= X_START11;
      originY_q      <= Y_START11;
      dir_q          <= 1'b0;
      descents_q     <= '0;
      dx_q           <= 4'(BASE_DX);
      stepPulse_q    <= 1'b0;
      descendPulse_q <= 1'b0;
      invaded_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      originX_q      <= originX_d;
      originY_q      <= originY_d;
      dir_q          <= dir_d;
      descents_q     <= descents_d;
      dx_q           <= dx_d;
      stepPulse_q    <= stepPulse_d;
      descendPulse_q <= descendPulse_d;
      invaded_q      <= invaded_d;
    end
  end

  assign rxFull   = $signed({2'b00, h_counter}) - $signed({1'b0, originX_q});
  assign ryFull   = $signed({2'b00, v_counter}) - $signed({1'b0, originY_q});
  assign inForm_d = ~rxFull[11] & (rxFull < FORM_W12) & ~ryFull[11] & (ryFull < FORM_H12);

  // Pixel stage 1: offset of the queried pixel from the formation origin.
  always_ff @(posedge clk) begin
    if (clear) begin
      rx_q     <= '0;
      ry_q     <= '0;
      inForm_q <= 1'b0;
    end else begin
      rx_q     <= rxFull[10:0];
      ry_q     <= ryFull[10:0];
      inForm_q <= inForm_d;
    end
  end

  // Cell lookup by threshold compare chain, then sprite box and alive test.
  always_comb begin
    colSel  = '0;
    colBase = '0;
    for (int k = 1; k < COLS; k++) begin
      if (rx_q >= 11'(k * CELL_W)) begin
        colSel  = COL_W'(k);
        colBase = 11'(k * CELL_W);
      end
    end
    rowSel  = '0;
    rowBase = '0;
    for (int k = 1; k < ROWS; k++) begin
      if (ry_q >= 11'(k * CELL_H)) begin
        rowSel  = ROW_W'(k);
        rowBase = 11'(k * CELL_H);
      end
    end
    rxMod    = rx_q - colBase;
    ryMod    = ry_q - rowBase;
    cellIdx  = IDX_W'(rowSel) * IDX_W'(COLS) + IDX_W'(colSel);
    aliveSel = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (cellIdx == IDX_W'(i)) aliveSel = alive[i];
    end
    pixIdx_d = inForm_q ? cellIdx : '0;
    pixHit_d = inForm_q & (rxMod < SPRITE_W11) & (ryMod < SPRITE_H11) & aliveSel;
  end

  // Pixel stage 2: registered query answer.
  always_ff @(posedge clk) begin
    if (clear) begin
      pixIdx_q <= '0;
      pixHit_q <= 1'b0;
    end else begin
      pixIdx_q <= pixIdx_d;
      pixHit_q <= pixHit_d;
    end
  end

  assign origin_x      = originX_q;
  assign origin_y      = originY_q;
  assign direction     = dir_q;
  assign dx_cur        = dx_q;
  assign step_pulse    = stepPulse_q;
  assign descend_pulse = descendPulse_q;
  assign invaded       = invaded_q;
  assign pix_idx       = pixIdx_q;
  assign pix_hit       = pixHit_q;

endmodule

// File: tb/tb_enemy_formation.sv
// tb_enemy_formation: randomized bench for enemy_formation with a
// behavioural model of the formation rules and the pixel query.
module tb_enemy_formation;

  localparam int ROWS = 2, COLS = 3, N = ROWS * COLS;
  localparam int CELL_W = 30, CELL_H = 30, SPRITE_W = 20, SPRITE_H = 16;
  localparam int X_START = 150, Y_START = 40, X_MIN = 120, X_MAX = 760;
  localparam int Y_LIMIT = 440, DY = 50, STEP_PERIOD = 4;
  localparam int BASE_DX = 1, MAX_DX = 8, KILLS_PER_DX = 2;
  localparam int IDX_W = $clog2(N);
  localparam logic [N-1:0] ALL_ALIVE = '1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             restart = 1'b0;
  logic             run = 1'b0;
  logic [N-1:0]     alive = '1;
  logic [9:0]       h_counter = '0;
  logic [9:0]       v_counter = '0;
  logic [10:0]      origin_x, origin_y;
  logic             direction;
  logic [3:0]       dx_cur;
  logic             step_pulse, descend_pulse, invaded;
  logic [IDX_W-1:0] pix_idx;
  logic             pix_hit;

  int vectors = 0;
  int miscompares = 0;

  // Reference state
  int mOx, mOy, mDir, mDesc, mDx, mTimer, mInv, mStep, mDp, mPixIdx, mPixHit;
  bit mDescendNext, mBoundsValid, s1In;
  int s1Rx, s1Ry;
  logic [N-1:0] mPrevAlive;

  enemy_formation #(
    .ROWS(ROWS), .COLS(COLS), .STEP_PERIOD(STEP_PERIOD), .KILLS_PER_DX(KILLS_PER_DX)
  ) dut (
    .clk(clk), .reset(reset), .restart(restart), .run(run), .alive(alive),
    .h_counter(h_counter), .v_counter(v_counter),
    .origin_x(origin_x), .origin_y(origin_y), .direction(direction), .dx_cur(dx_cur),
    .step_pulse(step_pulse), .descend_pulse(descend_pulse), .invaded(invaded),
    .pix_idx(pix_idx), .pix_hit(pix_hit)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectors++;
    if (observed != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  function automatic int countDead(input logic [N-1:0] m);
    int k = 0;
    for (int i = 0; i < N; i++) if (!m[i]) k++;
    return k;
  endfunction

  task automatic getBounds(input logic [N-1:0] m, output int lc, output int rc,
                           output int br, output bit none);
    none = (m == '0);
    lc = none ? 0 : COLS;
    rc = 0;
    br = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (m[r*COLS + c]) begin
          if (c < lc) lc = c;
          if (c > rc) rc = c;
          if (r > br) br = r;
        end
  endtask

  task automatic modelReset();
    mOx = X_START; mOy = Y_START; mDir = 0; mDesc = 0; mDx = BASE_DX;
    mTimer = 0; mInv = 0; mStep = 0; mDp = 0; mPixIdx = 0; mPixHit = 0;
    mDescendNext = 0; mBoundsValid = 0; s1In = 0; s1Rx = 0; s1Ry = 0;
  endtask

  // One clock edge of the formation rules, using the inputs held over that edge.
  task automatic modelEdge();
    int lc, rc, br, oxN, oyN, dirN, descN, dxN, timN, invN, stepN, dpN, tmp;
    bit none, en, tick, pendN;
    if (reset || restart) begin
      modelReset();
      return;
    end
    if (mBoundsValid) getBounds(mPrevAlive, lc, rc, br, none);
    else begin
      none = 1; lc = 0; rc = 0; br = 0;
    end
    en   = run && (mInv == 0);
    tick = en && (mTimer == STEP_PERIOD - 1);
    timN = en ? (tick ? 0 : mTimer + 1) : mTimer;
    invN = (mInv != 0 || (!none && mOy + br*CELL_H + SPRITE_H >= Y_LIMIT)) ? 1 : 0;
    tmp  = BASE_DX + mDesc + countDead(alive) / KILLS_PER_DX;
    dxN  = (tmp > MAX_DX) ? MAX_DX : tmp;
    oxN = mOx; oyN = mOy; dirN = mDir; descN = mDesc; pendN = mDescendNext;
    stepN = 0; dpN = 0;
    if (tick && !none) begin
      stepN = 1;
      if (mDescendNext) begin
        oyN = mOy + DY;
        descN = (mDesc >= 15) ? 15 : mDesc + 1;
        dpN = 1;
        pendN = 0;
      end else if (mDir == 0) begin
        if (mOx + rc*CELL_W + SPRITE_W - 1 + mDx > X_MAX) begin
          dirN = 1; pendN = 1;
        end else oxN = mOx + mDx;
      end else begin
        if (mOx + lc*CELL_W < X_MIN + mDx) begin
          dirN = 0; pendN = 1;
        end else oxN = mOx - mDx;
      end
    end
    // Pixel answer for the query captured one edge earlier.
    if (s1In) begin
      mPixIdx = (s1Ry / CELL_H) * COLS + (s1Rx / CELL_W);
      mPixHit = ((s1Rx % CELL_W) < SPRITE_W && (s1Ry % CELL_H) < SPRITE_H && alive[mPixIdx]) ? 1 : 0;
    end else begin
      mPixIdx = 0;
      mPixHit = 0;
    end
    s1Rx = int'(h_counter) - mOx;
    s1Ry = int'(v_counter) - mOy;
    s1In = (s1Rx >= 0 && s1Rx < COLS*CELL_W && s1Ry >= 0 && s1Ry < ROWS*CELL_H);
    mOx = oxN; mOy = oyN; mDir = dirN; mDesc = descN; mDx = dxN; mTimer = timN;
    mInv = invN; mStep = stepN; mDp = dpN; mDescendNext = pendN;
    mPrevAlive = alive; mBoundsValid = 1;
  endtask

  task automatic compareAll();
    checkOutput("origin_x", int'(origin_x), mOx);
    checkOutput("origin_y", int'(origin_y), mOy);
    checkOutput("direction", int'(direction), mDir);
    checkOutput("dx_cur", int'(dx_cur), mDx);
    checkOutput("step_pulse", int'(step_pulse), mStep);
    checkOutput("descend_pulse", int'(descend_pulse), mDp);
    checkOutput("invaded", int'(invaded), mInv);
    checkOutput("pix_idx", int'(pix_idx), mPixIdx);
    checkOutput("pix_hit", int'(pix_hit), mPixHit);
  endtask

  task automatic applyStimulus(input bit r, input bit rs, input bit rn,
                               input logic [N-1:0] al, input int h, input int v);
    @(negedge clk);
    reset = r; restart = rs; run = rn; alive = al;
    h_counter = 10'(h); v_counter = 10'(v);
    @(posedge clk);
    modelEdge();
    #1;
    compareAll();
  endtask

  function automatic int randH();
    int h;
    if ($urandom_range(0, 3) == 0) return $urandom_range(0, 1023);
    h = mOx - 20 + $urandom_range(0, 140);
    return (h < 0) ? 0 : (h > 1023 ? 1023 : h);
  endfunction

  function automatic int randV();
    int v;
    if ($urandom_range(0, 3) == 0) return $urandom_range(0, 1023);
    v = mOy - 10 + $urandom_range(0, 80);
    return (v < 0) ? 0 : (v > 1023 ? 1023 : v);
  endfunction

  initial begin
    logic [N-1:0] mask;
    int pulses, heldX, heldY;
    modelReset();
    mPrevAlive = '1;

    // Reset state
    repeat (3) applyStimulus(1, 0, 0, ALL_ALIVE, 0, 0);
    checkOutput("rst_origin_x", int'(origin_x), X_START);
    checkOutput("rst_origin_y", int'(origin_y), Y_START);
    checkOutput("rst_dx", int'(dx_cur), BASE_DX);
    checkOutput("rst_invaded", int'(invaded), 0);

    // Full formation sweeping right until the first wall turn and descent
    for (int i = 0; i < 2600; i++) applyStimulus(0, 0, 1, ALL_ALIVE, randH(), randV());

    // Rightmost column cleared: the wall is reached 30px later
    applyStimulus(0, 1, 0, ALL_ALIVE, 0, 0);
    mask = 6'b011011;
    for (int i = 0; i < 3500; i++)
      applyStimulus(0, 0, $urandom_range(0, 9) != 0, mask, randH(), randV());

    // Random kills, revivals, run gaps and occasional restarts
    applyStimulus(0, 1, 0, ALL_ALIVE, 0, 0);
    mask = ALL_ALIVE;
    for (int i = 0; i < 5000; i++) begin
      if (i % 150 == 149) begin
        if ($urandom_range(0, 3) == 0) mask = ALL_ALIVE;
        else mask[$urandom_range(0, N-1)] = 1'b0;
      end
      applyStimulus(0, $urandom_range(0, 1499) == 0, $urandom_range(0, 9) != 0,
                    mask, randH(), randV());
    end

    // Everyone dead: ticks are ignored and the origin holds
    applyStimulus(0, 0, 1, '0, randH(), randV());
    applyStimulus(0, 0, 1, '0, randH(), randV());
    heldX = int'(origin_x);
    heldY = int'(origin_y);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(0, 0, 1, '0, randH(), randV());
      pulses += int'(step_pulse) + int'(descend_pulse);
    end
    checkOutput("dead_pulses", pulses, 0);
    checkOutput("dead_hold_x", int'(origin_x), heldX);
    checkOutput("dead_hold_y", int'(origin_y), heldY);

    // March all the way down to the invasion line
    applyStimulus(0, 1, 0, ALL_ALIVE, 0, 0);
    for (int i = 0; i < 20000 && !invaded; i++)
      applyStimulus(0, 0, 1, ALL_ALIVE, randH(), randV());
    checkOutput("invaded_reached", int'(invaded), 1);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, 1, ALL_ALIVE, randH(), randV());
      pulses += int'(step_pulse);
    end
    checkOutput("frozen_pulses", pulses, 0);
    checkOutput("invaded_sticky", int'(invaded), 1);

    // Restart clears the invasion and re-homes the formation
    applyStimulus(0, 1, 0, ALL_ALIVE, 0, 0);
    checkOutput("restart_invaded", int'(invaded), 0);
    checkOutput("restart_origin_x", int'(origin_x), X_START);
    checkOutput("restart_origin_y", int'(origin_y), Y_START);

    // Directed pixel queries at origin (150,40)
    mask = 6'b011000;
    applyStimulus(0, 0, 0, mask, 185, 75);
    applyStimulus(0, 0, 0, mask, 175, 75);
    checkOutput("pix_185_idx", int'(pix_idx), 4);
    checkOutput("pix_185_hit", int'(pix_hit), 1);
    applyStimulus(0, 0, 0, mask, 100, 75);
    checkOutput("pix_175_hit", int'(pix_hit), 0);
    applyStimulus(0, 0, 0, mask, 100, 75);
    checkOutput("pix_100_idx", int'(pix_idx), 0);
    checkOutput("pix_100_hit", int'(pix_hit), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
